// File: rtl/game_loop_pkg.sv
// game_loop_pkg: shared state encoding and default tuning constants for the game-loop controller.
package game_loop_pkg;
   typedef enum logic [2:0] {
      WAITING    = 3'd0,
      RUNNING    = 3'd1,
      PAUSED     = 3'd2,
      CRASHED    = 3'd3,
      RESTARTING = 3'd4
   } game_state_t;
   localparam int DEF_FPS           = 60;
   localparam int DEF_SPEED_W       = 15;
   localparam int DEF_INIT_SPEED    = 6144;
   localparam int DEF_MAX_SPEED     = 13312;
   localparam int DEF_ACCEL         = 1;
   localparam int DEF_CLEAR_FRAMES  = 180;
   localparam int DEF_NUM_LIVES     = 3;
   localparam int DEF_INVULN_FRAMES = 90;
endpackage

// File: rtl/game_loop_ctrl_frame_tick.sv
// frame_tick: turns the painter_finished rising edge into a one-cycle update strobe and a wrapping frame timer.
module frame_tick #(
   parameter int FPS = 60,
   localparam int TW = $clog2(FPS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          painter_finished,
   input  logic          hold,
   output logic          update,
   output logic [TW-1:0] timer
);
   logic pf_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pf_q   <= 1'b0;
         update <= 1'b0;
         timer  <= '0;
      end else begin
         pf_q   <= painter_finished;
         update <= painter_finished && !pf_q;
         if (update && !hold) timer <= (timer == TW'(FPS - 1)) ? '0 : timer + 1'b1;
      end
   end
endmodule

// File: rtl/game_loop_ctrl.sv
// game_loop_ctrl: game FSM with frame tick, speed ramp, obstacle gating, lives and post-hit invulnerability.
// Define GAME_PAUSE_EN to add a pause toggle driven by rising edges of pause_req.
module game_loop_ctrl
   import game_loop_pkg::*;
#(
   parameter int FPS           = DEF_FPS,
   parameter int SPEED_W       = DEF_SPEED_W,
   parameter int INIT_SPEED    = DEF_INIT_SPEED,
   parameter int MAX_SPEED     = DEF_MAX_SPEED,
   parameter int ACCEL         = DEF_ACCEL,
   parameter int CLEAR_FRAMES  = DEF_CLEAR_FRAMES,
   parameter int NUM_LIVES     = DEF_NUM_LIVES,
   parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
   localparam int TW = $clog2(FPS),
   localparam int LW = $clog2(NUM_LIVES + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               painter_finished,
   input  logic               jumping,
   input  logic               collision,
   input  logic               pause_req,
   output logic               update,
   output logic [TW-1:0]      timer,
   output logic [SPEED_W-1:0] speed,
   output logic [2:0]         state,
   output logic               start,
   output logic               restart,
   output logic               has_obstacles,
   output logic [LW-1:0]      lives,
   output logic               invulnerable
);
   localparam int CW = $clog2(CLEAR_FRAMES + 2);
   localparam int IW = $clog2(INVULN_FRAMES + 1);
   game_state_t        st;
   logic               jmp_q, col_q, pause_edge, hit;
   logic [CW-1:0]      clr_cnt, clr_nxt;
   logic [IW-1:0]      inv_cnt;
   logic [SPEED_W:0]   sp_inc;
   logic [SPEED_W-1:0] sp_nxt;
   frame_tick #(.FPS(FPS)) u_tick (
      .clk              (clk),
      .rst_n            (rst_n),
      .painter_finished (painter_finished),
      .hold             (st == PAUSED),
      .update           (update),
      .timer            (timer)
   );
`ifdef GAME_PAUSE_EN
   logic pr_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pr_q <= 1'b0;
      else pr_q <= pause_req;
   end
   assign pause_edge = pause_req && !pr_q;
`else
   logic unused_pause;
   assign unused_pause = pause_req;
   assign pause_edge   = 1'b0;
`endif
   assign state        = st;
   assign invulnerable = (inv_cnt != '0);
   // one extra bit on the speed sum so the ceiling compare can never see a wrapped value
   always_comb begin
      sp_inc  = {1'b0, speed} + (SPEED_W + 1)'(ACCEL);
      sp_nxt  = (sp_inc > (SPEED_W + 1)'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED) : sp_inc[SPEED_W-1:0];
      clr_nxt = (clr_cnt == CW'(CLEAR_FRAMES + 1)) ? clr_cnt : clr_cnt + 1'b1;
      hit     = col_q && (inv_cnt == '0);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st            <= WAITING;
         jmp_q         <= 1'b0;
         col_q         <= 1'b0;
         speed         <= '0;
         start         <= 1'b0;
         restart       <= 1'b0;
         has_obstacles <= 1'b0;
         lives         <= LW'(NUM_LIVES);
         clr_cnt       <= '0;
         inv_cnt       <= '0;
      end else begin
         jmp_q <= jumping;
         col_q <= collision;
         case (st)
            WAITING: if (update && jumping) begin
               st      <= RUNNING;
               start   <= 1'b1;
               speed   <= SPEED_W'(INIT_SPEED);
               clr_cnt <= '0;
            end
            RUNNING: if (pause_edge) st <= PAUSED;
            else begin
               if (hit) begin
                  if (lives > LW'(1)) begin
                     lives   <= lives - 1'b1;
                     inv_cnt <= IW'(INVULN_FRAMES);
                  end else begin
                     lives <= '0;
                     st    <= CRASHED;
                  end
               end
               if (update) begin
                  speed   <= sp_nxt;
                  clr_cnt <= clr_nxt;
                  if (clr_nxt > CW'(CLEAR_FRAMES)) has_obstacles <= 1'b1;
                  if (inv_cnt != '0) inv_cnt <= inv_cnt - 1'b1;
               end
            end
            PAUSED: if (pause_edge) st <= RUNNING;
            CRASHED: if (jumping && !jmp_q) begin
               st            <= RESTARTING;
               restart       <= 1'b1;
               speed         <= '0;
               start         <= 1'b0;
               has_obstacles <= 1'b0;
               lives         <= LW'(NUM_LIVES);
               clr_cnt       <= '0;
               inv_cnt       <= '0;
            end
            RESTARTING: if (!jumping) begin
               st      <= WAITING;
               restart <= 1'b0;
            end
            default: st <= WAITING;
         endcase
      end
   end
endmodule

// File: tb/tb_game_loop_ctrl.sv
// tb_game_loop_ctrl: table-driven check of frame tick, speed ramp, lives, crash/restart and async reset.
module tb_game_loop_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, painter_finished, jumping, collision, pause_req;
   logic        update, start, restart, has_obstacles, invulnerable;
   logic [5:0]  timer;
   logic [14:0] speed;
   logic [2:0]  state;
   logic [1:0]  lives;
   int checks = 0, errors = 0;
   int n_upd = 0, exp_t = 0;
   logic mon_en = 1'b0;
   typedef struct {
      logic j; logic c; int n;
      int st; int spd; int lv; logic inv; logic hob; logic stt; logic rst;
   } vec_t;
   vec_t vecs[19];
   game_loop_ctrl dut (
      .clk(clk), .rst_n(rst_n), .painter_finished(painter_finished), .jumping(jumping),
      .collision(collision), .pause_req(pause_req), .update(update), .timer(timer),
      .speed(speed), .state(state), .start(start), .restart(restart),
      .has_obstacles(has_obstacles), .lives(lives), .invulnerable(invulnerable)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic frame();
      painter_finished = 1'b1;
      @(negedge clk);
      @(negedge clk);
      painter_finished = 1'b0;
      @(negedge clk);
   endtask
   task automatic step(input logic j, input logic c, input int n);
      @(negedge clk);
      jumping = j;
      if (c) begin
         collision = 1'b1;
         @(negedge clk);
         collision = 1'b0;
      end
      repeat (3) @(negedge clk);
      repeat (n) frame();
   endtask
   task automatic pause_pulse();
      @(negedge clk);
      pause_req = 1'b1;
      @(negedge clk);
      pause_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask
   always @(negedge clk) begin
      if (mon_en && update) begin
         chk("timer_seq", timer, exp_t);
         exp_t = (exp_t + 1) % 60;
         n_upd++;
      end
   end
   initial begin
      rst_n = 1'b0; painter_finished = 1'b0; jumping = 1'b0; collision = 1'b0; pause_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_state", state, 0);
      chk("rst_speed", speed, 0);
      chk("rst_lives", lives, 3);
      chk("rst_timer", timer, 0);
      chk("rst_update", update, 0);
      chk("rst_start", start, 0);
      chk("rst_restart", restart, 0);
      chk("rst_hob", has_obstacles, 0);
      chk("rst_inv", invulnerable, 0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      repeat (61) frame();
      mon_en = 1'b0;
      chk("update_count", n_upd, 61);
      chk("timer_wrap", timer, 1);
      //          j  c  n    st spd   lv inv hob stt rst
      vecs[0]  = '{0, 0, 1,   0, 0,    3, 0, 0, 0, 0};
      vecs[1]  = '{1, 0, 1,   1, 6144, 3, 0, 0, 1, 0};
      vecs[2]  = '{0, 0, 179, 1, 6323, 3, 0, 0, 1, 0};
      vecs[3]  = '{0, 0, 1,   1, 6324, 3, 0, 0, 1, 0};
      vecs[4]  = '{0, 0, 1,   1, 6325, 3, 0, 1, 1, 0};
      vecs[5]  = '{0, 1, 0,   1, 6325, 2, 1, 1, 1, 0};
      vecs[6]  = '{0, 0, 45,  1, 6370, 2, 1, 1, 1, 0};
      vecs[7]  = '{0, 1, 0,   1, 6370, 2, 1, 1, 1, 0};
      vecs[8]  = '{0, 0, 44,  1, 6414, 2, 1, 1, 1, 0};
      vecs[9]  = '{0, 1, 0,   1, 6414, 2, 1, 1, 1, 0};
      vecs[10] = '{0, 0, 1,   1, 6415, 2, 0, 1, 1, 0};
      vecs[11] = '{0, 1, 0,   1, 6415, 1, 1, 1, 1, 0};
      vecs[12] = '{0, 0, 90,  1, 6505, 1, 0, 1, 1, 0};
      vecs[13] = '{0, 1, 0,   3, 6505, 0, 0, 1, 1, 0};
      vecs[14] = '{0, 0, 3,   3, 6505, 0, 0, 1, 1, 0};
      vecs[15] = '{1, 0, 0,   4, 0,    3, 0, 0, 0, 1};
      vecs[16] = '{1, 0, 2,   4, 0,    3, 0, 0, 0, 1};
      vecs[17] = '{0, 0, 0,   0, 0,    3, 0, 0, 0, 0};
      vecs[18] = '{1, 0, 1,   1, 6144, 3, 0, 0, 1, 0};
      for (int i = 0; i < 19; i++) begin
         step(vecs[i].j, vecs[i].c, vecs[i].n);
         chk($sformatf("v%0d_state", i), state, vecs[i].st);
         chk($sformatf("v%0d_speed", i), speed, vecs[i].spd);
         chk($sformatf("v%0d_lives", i), lives, vecs[i].lv);
         chk($sformatf("v%0d_inv", i), invulnerable, vecs[i].inv);
         chk($sformatf("v%0d_hob", i), has_obstacles, vecs[i].hob);
         chk($sformatf("v%0d_start", i), start, vecs[i].stt);
         chk($sformatf("v%0d_restart", i), restart, vecs[i].rst);
      end
      step(0, 0, 7167);
      chk("ramp_13311", speed, 13311);
      frame();
      chk("ramp_max", speed, 13312);
      frame();
      chk("ramp_hold", speed, 13312);
      step(0, 1, 0);
      step(0, 0, 90);
      step(0, 1, 0);
      step(0, 0, 90);
      step(0, 1, 0);
      chk("crash_state", state, 3);
      chk("crash_speed", speed, 13312);
      step(1, 0, 0);
      chk("restart_state", state, 4);
      chk("restart_flag", restart, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", state, 0);
      chk("arst_restart", restart, 0);
      chk("arst_lives", lives, 3);
      chk("arst_speed", speed, 0);
      chk("arst_timer", timer, 0);
      chk("arst_update", update, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 0);
      chk("post_rst_state", state, 0);
      step(1, 0, 1);
      step(0, 0, 5);
      chk("pre_pause_speed", speed, 6149);
      chk("pre_pause_timer", timer, 6);
      pause_pulse();
`ifdef GAME_PAUSE_EN
      chk("paused_state", state, 2);
      step(0, 0, 10);
      chk("paused_timer", timer, 6);
      chk("paused_speed", speed, 6149);
      step(0, 1, 0);
      chk("paused_col_masked", lives, 3);
      pause_pulse();
      chk("resumed_state", state, 1);
`else
      chk("pause_ignored", state, 1);
`endif
      step(0, 0, 1);
      chk("resume_speed", speed, 6150);
      chk("resume_timer", timer, 7);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
